// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch slice: word sizes, reset address
// and fetch state encoding.
package pc_one_defs;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of ROM, decode and redirect signals around the fetch stage.
// master = fetch stage, slave = surrounding ROM/decode/branch logic.
interface fetch_stage_if;
  import pc_one_defs::*;

  logic [XLEN-1:0] rom_pc;
  logic [ILEN-1:0] rom_instruction;
  logic            dec_valid;
  logic            dec_ready;
  logic [ILEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halted;
  logic            misaligned;

  modport master (
    output rom_pc,
    input  rom_instruction,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    input  redirect_valid,
    input  redirect_pc,
    output halted,
    output misaligned
  );

  modport slave (
    input  rom_pc,
    output rom_instruction,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    output redirect_valid,
    output redirect_pc,
    input  halted,
    input  misaligned
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Show-ahead prefetch queue: head entry is visible on dout straight from storage.
// A push into a full queue is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Flush wins over everything; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation, prefetch queue feeding
// decode, redirect handling and a halt on misaligned redirect targets.
module fetch_stage
  import pc_one_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     next_state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  next_pc;
  logic             misaligned_q;
  logic             next_misaligned;
  logic             enq;
  logic             pop;
  logic             flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [XLEN+ILEN-1:0] fifo_dout;

  assign bus.rom_pc     = fetch_pc;
  assign bus.dec_valid  = (state == ST_RUN) && (fifo_count != '0);
  assign bus.dec_pc     = fifo_dout[XLEN+ILEN-1:ILEN];
  assign bus.dec_instr  = fifo_dout[ILEN-1:0];
  assign bus.halted     = (state == ST_HALT);
  assign bus.misaligned = misaligned_q;
  assign pop            = bus.dec_valid && bus.dec_ready;

  always_comb begin
    assert (fifo_empty == (fifo_count == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      fetch_pc     <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state        <= next_state;
      fetch_pc     <= next_pc;
      misaligned_q <= next_misaligned;
    end
  end

  // A redirect always empties the queue; only an aligned target moves the PC,
  // a misaligned one parks the stage in HALT until reset.
  always_comb begin
    next_state      = state;
    next_pc         = fetch_pc;
    next_misaligned = misaligned_q;
    enq             = 1'b0;
    flush           = 1'b0;
    if (state == ST_RUN) begin
      if (bus.redirect_valid) begin
        flush = 1'b1;
        if (is_aligned(bus.redirect_pc)) begin
          next_pc = bus.redirect_pc;
        end else begin
          next_state      = ST_HALT;
          next_misaligned = 1'b1;
        end
      end else if ((fifo_count < CW'(DEPTH)) || pop) begin
        enq     = 1'b1;
        next_pc = fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .pop   (pop),
    .flush (flush),
    .din   ({fetch_pc, bus.rom_instruction}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    assert (!(enq && fifo_full && !pop));
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rom_pc  output  32  fetch address to instruction ROM.
REQ-006 rom_instruction  input  32  ROM word for rom_pc, valid in the same cycle (combinational read).
REQ-007 dec_valid  output  1  head queue entry present.
REQ-008 dec_ready  input  1  decode accepts head entry.
REQ-009 dec_instr  output  32  head entry instruction.
REQ-010 dec_pc  output  32  head entry address.
REQ-011 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 halted  output  1  fetch stopped (HALT state).
REQ-014 misaligned  output  1  sticky flag: misaligned redirect target received.

Function
REQ-015 Register fetch_pc SHALL drive rom_pc directly; no other logic on that path.
REQ-016 States: RUN, HALT; only reset leaves HALT.
REQ-017 pop SHALL be dec_valid && dec_ready; enq SHALL be (state==RUN) && !redirect_valid && (count<DEPTH || pop).
REQ-018 On enq, {fetch_pc, rom_instruction} SHALL be written at queue tail and fetch_pc SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 The queue SHALL be show-ahead: dec_valid = (count!=0); dec_instr/dec_pc reflect head combinationally from storage.
REQ-020 Simultaneous enq and pop with queue full SHALL both take effect; count unchanged.
REQ-021 With queue empty, a word fetched in cycle N SHALL appear at decode in cycle N+1 (no same-cycle bypass).
REQ-022 In RUN, redirect_valid with redirect_pc[1:0]==0 SHALL flush the queue (count, pointers to 0), load fetch_pc<=redirect_pc, suppress enq that cycle.
REQ-023 A pop completing in a redirect cycle counts as delivered; the flush still empties the queue.
REQ-024 Redirect latency: redirect in cycle N -> rom_pc==target in N+1 -> dec_valid with dec_pc==target in N+2.
REQ-025 In RUN, redirect_valid with redirect_pc[1:0]!=0 SHALL flush the queue, leave fetch_pc unchanged, set misaligned, and enter HALT.
REQ-026 In HALT: no enq, redirect_valid ignored, dec_valid=0, halted=1.
REQ-027 dec_ready while dec_valid=0 SHALL have no effect.
REQ-028 Queue count width SHALL be $clog2(DEPTH)+1 bits.

Reset
REQ-029 While rst=1: fetch_pc=RESET_PC, count=0, pointers=0, state=RUN, dec_valid=0, halted=0, misaligned=0; queue storage not reset.
REQ-030 First rising edge after rst deasserts SHALL enq the word at RESET_PC; dec_valid=1 thereafter.
REQ-031 rst asserted mid-operation SHALL discard all queued entries and any HALT/misaligned state immediately (asynchronously).

Structure
REQ-032 Shared package/header pc_one_defs SHALL hold XLEN=32, ILEN=32, default RESET_PC, and state encodings.
REQ-033 Queue SHALL be a sub-module fetch_fifo (parameter DEPTH, WIDTH=64, push/pop/flush, full/empty/count); the state machine and fetch_pc stay in fetch_stage.

Verification
REQ-034 Reset, ROM word i = 32'h1000_0000+i, dec_ready=1 -> dec_pc sequence 0,4,8,… one per cycle from the second post-reset cycle; dec_instr matches.
REQ-035 dec_ready=0 for 10 cycles -> count saturates at 4, rom_pc holds 32'h10, no entry lost or duplicated after release.
REQ-036 Redirect to 32'h200 while queue holds 3 entries and dec_ready=1 -> head in that cycle delivered; next delivered dec_pc==32'h200, two cycles after redirect.
REQ-037 Redirect to 32'h202 -> misaligned=1, halted=1, dec_valid=0; a later aligned redirect ignored; rst clears both.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst pulse mid-stream with full queue -> dec_valid=0 during reset; first post-reset dec_pc==RESET_PC.
